// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: instruction classes, opcode/funct/ALU-op constants and the word encoder.
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    CLS_ADDI  = 3'd0,
    CLS_RTYPE = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_J     = 3'd5
  } req_class_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  // Returns {illegal, word}; illegal requests encode as an all-zero word.
  function automatic logic [32:0] encode(input logic [2:0] cls, input logic [2:0] aluop,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [15:0] imm,
                                         input logic [25:0] tgt);
    logic [5:0] fn;
    logic fn_ok;
    fn_ok = 1'b1;
    case (aluop)
      ALU_ADD: fn = FN_ADD;
      ALU_SUB: fn = FN_SUB;
      ALU_AND: fn = FN_AND;
      ALU_OR:  fn = FN_OR;
      ALU_SLT: fn = FN_SLT;
      default: begin fn = 6'd0; fn_ok = 1'b0; end
    endcase
    case (cls)
      CLS_ADDI:  encode = {1'b0, OP_ADDI, rs, rt, imm};
      CLS_RTYPE: encode = fn_ok ? {1'b0, OP_RTYPE, rs, rt, rd, 5'd0, fn} : {1'b1, 32'd0};
      CLS_LW:    encode = {1'b0, OP_LW, rs, rt, imm};
      CLS_SW:    encode = {1'b0, OP_SW, rs, rt, imm};
      CLS_BEQ:   encode = {1'b0, OP_BEQ, rs, rt, imm};
      CLS_J:     encode = {1'b0, OP_J, tgt};
      default:   encode = {1'b1, 32'd0};
    endcase
  endfunction
endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous FIFO with clear; a pop frees the slot for a same-cycle push when full.
module enc_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= do_push ? wp + 1'b1 : wp;
      rp  <= do_pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction requests into 32-bit words and streams them to instruction memory.
// Defining ENCODER_CHECKSUM_EN adds the csum output (XOR of all words written since load_start).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [2:0]        req_aluop,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic              busy
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0] state;
  logic [32:0] enc;
  logic [31:0] head;
  logic clr, push, pop, wr, empty, full;
  assign enc        = encode(req_class, req_aluop, req_rs, req_rt, req_rd, req_imm, req_target);
  assign clr        = state == S_IDLE && load_start;
  assign req_ready  = state == S_LOAD && !full;
  assign push       = req_valid && req_ready;
  assign imem_we    = !empty && !err_overflow;
  assign wr         = imem_we && imem_ready;
  // After overflow the remaining words are drained silently so the load can still finish.
  assign pop        = wr || (!empty && err_overflow);
  assign imem_wdata = imem_we ? head : 32'd0;
  assign done       = state == S_DONE;
  assign busy       = state != S_IDLE;
  enc_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (enc[31:0]),
    .dout  (head),
    .empty (empty),
    .full  (full)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      imem_addr    <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (clr) begin
      state        <= S_LOAD;
      imem_addr    <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (push && enc[32]) err_illegal <= 1'b1;
      if (wr && &imem_addr) err_overflow <= 1'b1;
      if (wr && !(&imem_addr)) imem_addr <= imem_addr + 1'b1;
      state <= state == S_LOAD  ? ((push && req_last) ? S_DRAIN : S_LOAD) :
               state == S_DRAIN ? (empty ? S_DONE : S_DRAIN) : S_IDLE;
    end
`ifdef ENCODER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (clr) csum <= '0;
    else if (wr) csum <= csum ^ head;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and sequence checks of instr_encoder (default and ADDR_W=2 instances).
module tb_instr_encoder;
  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  aluop;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    logic        ill;
  } vec_t;
  logic clk = 0, rst_n = 0, load_start = 0, req_valid = 0, req_last = 0, imem_ready = 0, sel = 0;
  logic [2:0] req_class = 0, req_aluop = 0;
  logic [4:0] req_rs = 0, req_rt = 0, req_rd = 0;
  logic [15:0] req_imm = 0;
  logic [25:0] req_target = 0;
  logic rdy1, we1, done1, ill1, ovf1, busy1, rdy2, we2, done2, ill2, ovf2, busy2;
  logic [7:0] addr1;
  logic [1:0] addr2;
  logic [31:0] wd1, wd2;
  logic v1, v2, ls1, ls2, rdy, busy_s;
  int checks = 0, failures = 0, acc = 0, dn1 = 0, dn2 = 0;
  int wa[$], wdq[$], wa2[$];
  vec_t tv[12];
  assign v1 = req_valid && !sel;
  assign v2 = req_valid && sel;
  assign ls1 = load_start && !sel;
  assign ls2 = load_start && sel;
  assign rdy = sel ? rdy2 : rdy1;
  assign busy_s = sel ? busy2 : busy1;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] csum1, csum2;
`endif
  always #5 clk = ~clk;
  instr_encoder u1 (
    .clk(clk), .rst_n(rst_n), .load_start(ls1), .req_valid(v1), .req_ready(rdy1),
    .req_class(req_class), .req_aluop(req_aluop), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .imem_ready(imem_ready),
    .done(done1), .err_illegal(ill1), .err_overflow(ovf1), .busy(busy1)
`ifdef ENCODER_CHECKSUM_EN
    , .csum(csum1)
`endif
  );
  instr_encoder #(.ADDR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .load_start(ls2), .req_valid(v2), .req_ready(rdy2),
    .req_class(req_class), .req_aluop(req_aluop), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .imem_ready(imem_ready),
    .done(done2), .err_illegal(ill2), .err_overflow(ovf2), .busy(busy2)
`ifdef ENCODER_CHECKSUM_EN
    , .csum(csum2)
`endif
  );
  always @(negedge clk) begin
    if (we1 && imem_ready) begin wa.push_back(int'(addr1)); wdq.push_back(int'(wd1)); end
    if (we2 && imem_ready) wa2.push_back(int'(addr2));
    if (done1) dn1++;
    if (done2) dn2++;
    if (v1 && rdy1) acc++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send(input vec_t v, input logic last);
    int n = 0;
    @(negedge clk);
    req_class = v.cls; req_aluop = v.aluop; req_rs = v.rs; req_rt = v.rt; req_rd = v.rd;
    req_imm = v.imm; req_target = v.tgt; req_last = last; req_valid = 1;
    while (!rdy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1 req_valid = 0; req_last = 0;
  endtask
  task automatic start_load();
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_s && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("idle_timeout", 1, 0);
  endtask
  task automatic clear_mon();
    wa.delete(); wdq.delete(); wa2.delete(); dn1 = 0; dn2 = 0; acc = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, rdy1, 0);
    chk({tag, "_we"}, we1, 0);
    chk({tag, "_addr"}, addr1, 0);
    chk({tag, "_wdata"}, wd1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_ill"}, ill1, 0);
    chk({tag, "_ovf"}, ovf1, 0);
  endtask
  function automatic vec_t mk(input logic [2:0] c, input logic [2:0] a, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                              input logic [25:0] g, input logic [31:0] e, input logic il);
    vec_t v;
    v.cls = c; v.aluop = a; v.rs = s; v.rt = t; v.rd = d; v.imm = i; v.tgt = g; v.exp = e; v.ill = il;
    return v;
  endfunction
  initial begin
    logic [31:0] x;
    tv[0]  = mk(3'd0, 3'd0, 5'd0,  5'd8,  5'd0,  16'h0005, 26'd0,        32'h20080005, 0);
    tv[1]  = mk(3'd1, 3'b010, 5'd8, 5'd9, 5'd10, 16'h0000, 26'd0,        32'h01095020, 0);
    tv[2]  = mk(3'd2, 3'd0, 5'd8,  5'd9,  5'd0,  16'h0004, 26'd0,        32'h8D090004, 0);
    tv[3]  = mk(3'd5, 3'd0, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h10,       32'h08000010, 0);
    tv[4]  = mk(3'd3, 3'd0, 5'd29, 5'd31, 5'd0,  16'hFFFC, 26'd0,        32'hAFBFFFFC, 0);
    tv[5]  = mk(3'd4, 3'd0, 5'd1,  5'd2,  5'd0,  16'h0003, 26'd0,        32'h10220003, 0);
    tv[6]  = mk(3'd1, 3'b110, 5'd1, 5'd2, 5'd3,  16'h0000, 26'd0,        32'h00221822, 0);
    tv[7]  = mk(3'd1, 3'b000, 5'd1, 5'd2, 5'd3,  16'h0000, 26'd0,        32'h00221824, 0);
    tv[8]  = mk(3'd1, 3'b001, 5'd1, 5'd2, 5'd3,  16'h0000, 26'd0,        32'h00221825, 0);
    tv[9]  = mk(3'd1, 3'b111, 5'd1, 5'd2, 5'd3,  16'h0000, 26'd0,        32'h0022182A, 0);
    tv[10] = mk(3'd1, 3'b011, 5'd1, 5'd2, 5'd3,  16'h0000, 26'd0,        32'h00000000, 1);
    tv[11] = mk(3'd6, 3'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000, 1);
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst_n = 1;
    clear_mon(); imem_ready = 1;
    start_load();
    for (int i = 0; i < 12; i++) send(tv[i], i == 11);
    wait_idle();
    chk("tbl_count", wa.size(), 12);
    x = 0;
    for (int i = 0; i < 12 && i < wa.size(); i++) begin
      chk($sformatf("tbl_addr%0d", i), wa[i], i);
      chk($sformatf("tbl_word%0d", i), wdq[i], tv[i].exp);
      x ^= tv[i].exp;
    end
    chk("tbl_ill", ill1, 1);
    chk("tbl_ovf", ovf1, 0);
    chk("tbl_done", dn1, 1);
`ifdef ENCODER_CHECKSUM_EN
    chk("tbl_csum", csum1, x);
`endif
    clear_mon();
    start_load();
    send(tv[1], 0); send(tv[2], 0); send(tv[3], 1);
    wait_idle();
    chk("seq_count", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("seq_a0", wa[0], 0); chk("seq_w0", wdq[0], 32'h01095020);
      chk("seq_a1", wa[1], 1); chk("seq_w1", wdq[1], 32'h8D090004);
      chk("seq_a2", wa[2], 2); chk("seq_w2", wdq[2], 32'h08000010);
    end
    chk("seq_ill_cleared", ill1, 0);
    clear_mon(); imem_ready = 0;
    start_load();
    fork
      for (int i = 0; i < 6; i++)
        send(mk(3'd0, 3'd0, 5'd0, 5'(i), 5'd0, 16'(i), 26'd0, 32'd0, 0), i == 5);
      begin
        @(negedge clk) load_start = 1;
        @(negedge clk) load_start = 0;
        repeat (8) @(negedge clk);
        chk("bp_accepted", acc, 4);
        chk("bp_ready_low", rdy1, 0);
        chk("bp_no_write", wa.size(), 0);
        imem_ready = 1;
      end
    join
    wait_idle();
    chk("bp_count", wa.size(), 6);
    for (int i = 0; i < 6 && i < wa.size(); i++) begin
      chk($sformatf("bp_addr%0d", i), wa[i], i);
      chk($sformatf("bp_word%0d", i), wdq[i], 32'h20000000 | (i << 16) | i);
    end
    chk("bp_done", dn1, 1);
    sel = 1; clear_mon();
    start_load();
    for (int i = 0; i < 5; i++)
      send(mk(3'd0, 3'd0, 5'd0, 5'd1, 5'd0, 16'(i), 26'd0, 32'd0, 0), i == 4);
    wait_idle();
    chk("ovf_count", wa2.size(), 4);
    for (int i = 0; i < 4 && i < wa2.size(); i++) chk($sformatf("ovf_addr%0d", i), wa2[i], i);
    chk("ovf_flag", ovf2, 1);
    chk("ovf_nowrap", addr2, 3);
    chk("ovf_we", we2, 0);
    chk("ovf_done", dn2, 1);
    sel = 0; clear_mon(); imem_ready = 0;
    start_load();
    send(tv[0], 0); send(tv[2], 0);
    #3 rst_n = 0;
    #1 chk_reset("mid");
    imem_ready = 1;
    repeat (2) @(negedge clk);
    chk("mid_no_write", wa.size(), 0);
    rst_n = 1;
    start_load();
    send(tv[0], 1);
    wait_idle();
    chk("mid_count", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("mid_addr", wa[0], 0);
      chk("mid_word", wdq[0], 32'h20080005);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: encoded-word buffer entries (power of 2, at least 2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port load_start, input, 1 bit, one-cycle pulse that begins a program load at address 0.
REQ-006 SHALL have port req_valid / req_ready, input / output, 1 bit each, instruction request handshake.
REQ-007 SHALL have port req_class, input, 3 bits, instruction class: ADDI, RTYPE, LW, SW, BEQ, J.
REQ-008 SHALL have port req_aluop, input, 3 bits, ALU op for RTYPE: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-009 SHALL have ports req_rs, req_rt, req_rd, input, 5 bits each, register fields.
REQ-010 SHALL have ports req_imm (input, 16 bits) and req_target (input, 26 bits), immediate and jump target.
REQ-011 SHALL have port req_last, input, 1 bit, marks the final instruction of the load.
REQ-012 SHALL have ports imem_we (output, 1 bit), imem_addr (output, ADDR_W bits), imem_wdata (output, 32 bits), and imem_ready (input, 1 bit), the memory write port.
REQ-013 SHALL have ports done (output, 1 bit, one-cycle pulse), err_illegal (output, 1 bit, sticky), err_overflow (output, 1 bit, sticky), and busy (output, 1 bit).

Function
REQ-014 Encoding SHALL be: ADDI {001000,rs,rt,imm}; LW {100011,rs,rt,imm}; SW {101011,rs,rt,imm}; BEQ {000100,rs,rt,imm}; J {000010,target}.
REQ-015 RTYPE SHALL encode as {000000,rs,rt,rd,00000,funct}, with funct 100000/100010/100100/100101/101010 for add/sub/and/or/slt.
REQ-016 An undefined req_class or RTYPE aluop SHALL encode as 0x00000000 and set err_illegal; the word is still written.
REQ-017 The FSM SHALL have states IDLE, LOAD, DRAIN, DONE: IDLE->LOAD on load_start; LOAD->DRAIN on accepting req_last; DRAIN->DONE when the FIFO is empty; DONE->IDLE after one cycle.
REQ-018 req_ready SHALL equal (state==LOAD) and FIFO not full; a transfer occurs on req_valid and req_ready.
REQ-019 An accepted request SHALL be encoded into the FIFO the same edge; imem_we SHALL assert at the earliest on the next cycle.
REQ-020 imem_we SHALL equal FIFO non-empty and no overflow; the head SHALL pop and imem_addr SHALL increment on imem_we and imem_ready.
REQ-021 Simultaneous push and pop SHALL hold occupancy unchanged; full with a pop SHALL accept a push the same cycle.
REQ-022 A write at address 2^ADDR_W-1 SHALL set err_overflow; later words SHALL be discarded (popped, no imem_we), and the address SHALL NOT wrap.
REQ-023 done SHALL pulse in the DONE state; busy SHALL equal state != IDLE.
REQ-024 load_start outside IDLE SHALL be ignored.
REQ-025 load_start in IDLE SHALL clear imem_addr, the FIFO, err_illegal and err_overflow.

Reset
REQ-026 rst_n low SHALL force state IDLE, FIFO empty, imem_addr 0, imem_we 0, req_ready 0, done 0, busy 0, err_illegal 0, err_overflow 0, and imem_wdata 0.
REQ-027 Reset mid-load SHALL abort immediately; no partial write SHALL occur after rst_n falls.

Configuration
REQ-028 With ENCODER_CHECKSUM_EN defined, output csum (32 bits) SHALL hold the XOR of all words written since load_start, cleared by reset and by load_start.
REQ-029 Without ENCODER_CHECKSUM_EN, the csum port SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the req_class enum, the opcode and funct constants, and the 3-bit ALU op codes shared with the control decoder.
REQ-031 The FIFO SHALL be sub-module enc_fifo (synchronous, parameterized width and depth); the encoder datapath SHALL be combinational within instr_encoder.

Verification
REQ-032 ADDI rs=0 rt=8 imm=5 -> imem_wdata 0x20080005 at imem_addr 0.
REQ-033 RTYPE add rs=8 rt=9 rd=10, then LW rs=8 rt=9 imm=4 -> 0x01095020 at addr 0 and 0x8D090004 at addr 1; J target 0x10 -> 0x08000010.
REQ-034 RTYPE aluop 011 -> word 0x00000000 written and err_illegal=1.
REQ-035 imem_ready held low for 10 cycles with 6 requests -> req_ready drops after 4 accepted, no data loss, addresses 0..5 in order, done pulses once.
REQ-036 ADDR_W=2 with 5 requests -> addresses 0..3 written, err_overflow=1, no fifth write.
REQ-037 rst_n asserted mid-load with 2 words buffered -> all outputs at reset values; the next load starts at addr 0.
